// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// The state encoding is fixed so it can be probed directly on a board.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int CNT_W       = 4;
    localparam int DATA_W      = 32;
    localparam int TV_W        = 16;
    localparam int ADDR_BYTE_W = 32;

    // Word accesses only: any set byte-offset bit is a misaligned request.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_store.sv
// Word store for the responder: one write port, one registered read port,
// and a combinational tap on a fixed word. Every word clears on reset.
module dmem_store
    import dmem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TEST_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_rclr,
    output logic [DATA_W-1:0] o_rdata,
    output logic [TV_W-1:0]   o_tap
);

    localparam int unsigned      DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] TAP_IDX = ADDR_W'(TEST_ADDR);

    logic [DATA_W-1:0] w_words [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // One register per word so the whole array can be cleared asynchronously.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [DATA_W-1:0] r_word;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                r_word <= '0;
            end else if (i_we && (i_waddr == ADDR_W'(gi))) begin
                r_word <= i_wdata;
            end
        end

        assign w_words[gi] = r_word;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rdata <= '0;
        end else if (i_rclr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_words[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
    assign o_tap   = w_words[TAP_IDX][TV_W-1:0];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the MEM stage: accepts one word request,
// stalls the pipeline for the modelled latency, then acks for one cycle.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned TEST_ADDR = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ReqM,
    input  logic                   WeM,
    input  logic [ADDR_BYTE_W-1:0] AddrM,
    input  logic [DATA_W-1:0]      WDataM,
    output logic [DATA_W-1:0]      RDataM,
    output logic                   AckM,
    output logic                   StallMem,
    output logic                   MisalignM,
    output logic [TV_W-1:0]        test_value
);

    localparam logic [CNT_W-1:0] LAT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;

    logic              r_we;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_misalign;

    logic [ADDR_W-1:0] w_req_idx;
    logic              w_req_mis;
    logic              w_accept;
    logic              w_access;
    logic              w_acc_we;
    logic [ADDR_W-1:0] w_acc_idx;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_rclr;
    logic              w_set_mis;
    logic [DATA_W-1:0] w_rdata;
    logic [TV_W-1:0]   w_tap;
    logic              w_unused_addr;

    // Upper address bits are dropped so the word index wraps.
    assign w_req_idx     = AddrM[ADDR_W+1:2];
    assign w_req_mis     = is_misaligned(AddrM[1:0]);
    assign w_accept      = (r_state == IDLE) && ReqM;
    assign w_unused_addr = ^AddrM[ADDR_BYTE_W-1:ADDR_W+2];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_access     = 1'b0;
        w_acc_we     = r_we;
        w_acc_idx    = r_idx;
        w_acc_wdata  = r_wdata;
        w_rclr       = 1'b0;
        w_set_mis    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (ReqM) begin
                    if (w_req_mis) begin
                        w_set_mis    = 1'b1;
                        w_rclr       = 1'b1;
                        w_state_next = ACK;
                    end else if (LATENCY == 0) begin
                        // Zero latency accesses straight from the live inputs.
                        w_access     = 1'b1;
                        w_acc_we     = WeM;
                        w_acc_idx    = w_req_idx;
                        w_acc_wdata  = WDataM;
                        w_state_next = ACK;
                    end else begin
                        w_cnt_next   = LAT_LOAD;
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_state_next = ACK;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ACK: begin
                // ReqM here is still the instruction being completed.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= WeM;
            r_idx   <= w_req_idx;
            r_wdata <= WDataM;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_misalign <= 1'b0;
        end else if (w_set_mis) begin
            r_misalign <= 1'b1;
        end
    end

    dmem_store #(
        .ADDR_W    (ADDR_W),
        .TEST_ADDR (TEST_ADDR)
    ) u_store (
        .CLK     (CLK),
        .RST     (RST),
        .i_we    (w_access & w_acc_we),
        .i_waddr (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .i_re    (w_access & ~w_acc_we),
        .i_raddr (w_acc_idx),
        .i_rclr  (w_rclr),
        .o_rdata (w_rdata),
        .o_tap   (w_tap)
    );

    // Gated by RST so the hazard unit sees no stall while reset is held.
    assign StallMem   = RST & (((r_state == IDLE) & ReqM) | (r_state == WAIT));
    assign AckM       = (r_state == ACK);
    assign RDataM     = w_rdata;
    assign MisalignM  = r_misalign;
    assign test_value = w_tap;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the pipelined datapath's MEM-stage load/store requests. Accepts one word request at a time, models a configurable access latency, and asserts a stall to the hazard unit until the access completes. On completion it returns registered read data with a one-cycle acknowledge. It also exports the low half of a designated word as the board-level `test_value`. It replaces the single-cycle data memory wherever a multi-cycle memory is required.

## Interface
- `ADDR_W`, 8: word-address width; the store holds 2^ADDR_W 32-bit words.
- `LATENCY`, 2: wait cycles between acceptance and acknowledge; legal range 0..15.
- `TEST_ADDR`, 0: word index exported on `test_value`.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `ReqM`  in  1  request valid; driven as MemWriteM | MemtoRegM.
- `WeM`  in  1  1 = store, 0 = load.
- `AddrM`  in  32  byte address (ALUOutM).
- `WDataM`  in  32  store data (WriteDataM).
- `RDataM`  out  32  registered load data; valid while `AckM` = 1.
- `AckM`  out  1  one-cycle completion pulse.
- `StallMem`  out  1  freeze request to the hazard unit (stall F/D/E/M, bubble W).
- `MisalignM`  out  1  sticky: a request had `AddrM[1:0]` != 0.
- `test_value`  out  16  `mem[TEST_ADDR][15:0]`.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - WAIT: modelling access latency, with 4-bit counter `cnt`.
  - ACK: completion cycle.
- **IDLE, `ReqM` = 1:**
  - Latch `WeM`, word index `AddrM[ADDR_W+1:2]`, and `WDataM`.
  - Misaligned address: set `MisalignM`, go to ACK with `RDataM` = 0. No write occurs.
  - Aligned, `LATENCY` = 0: perform the access and go to ACK.
  - Aligned, `LATENCY` > 0: go to WAIT with `cnt` = `LATENCY` - 1.
- **WAIT:**
  - `cnt` = 0: perform the access from the latched values and go to ACK.
  - Otherwise decrement `cnt`.
- **Access:**
  - Store: write `mem[idx]`; `RDataM` keeps its previous value.
  - Load: `RDataM` <= `mem[idx]`.
- **ACK:** `AckM` = 1. `ReqM` is ignored because it still belongs to the same instruction. Return to IDLE unconditionally.
- **StallMem:** combinational. It is 1 in IDLE when `ReqM` = 1, and 1 throughout WAIT. It is 0 in ACK, so the pipeline advances on the edge leaving ACK.
- **Input stability:** input changes during WAIT are ignored; only the latched values are used.
- **Address wrap:** address bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^ADDR_W words.
- **Load data:** after a load the data stays on `RDataM` until the next load or reset.
- **Reset:** may occur in any state, including mid-access.
  - State returns to IDLE.
  - `cnt`, `RDataM`, `AckM`, `MisalignM` and all memory words go to 0.
  - An in-flight store is discarded.
  - `StallMem` = 0, `test_value` = 0.

## Timing
- A request first seen in IDLE at cycle 0 stalls for cycles 0..`LATENCY`. `AckM` is high in cycle `LATENCY` + 1.
- Back-to-back requests: the next request can be accepted one cycle after ACK, in IDLE. There is no bubble beyond this.
- A misaligned request completes after one stall cycle, regardless of `LATENCY`.
- `test_value` tracks a store to `TEST_ADDR` in the cycle after the write edge, i.e. during ACK.

## Structure
- **Package `dmem_resp_pkg`:**
  - State enum: IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2.
  - Counter width constant = 4.
  - Data width constant = 32.
- **Sub-module `dmem_store`:**
  - The word array with async clear.
  - One synchronous write port, one synchronous read port, and a combinational tap at `TEST_ADDR`.
- **FSM, counter and request latch:** live in the top level.

## Test plan
- **Store then load, `LATENCY` = 2:**
  - Stimulus: store 0xDEADBEEF to 0x10, then load 0x10.
  - Response: each access stalls 3 cycles. `AckM` pulses in cycle 3 of each access. The load returns `RDataM` = 0xDEADBEEF.
- **`LATENCY` = 0:**
  - Stimulus: a load of a word at reset value.
  - Response: 1 stall cycle; `AckM` in cycle 1; `RDataM` = 0.
- **Misaligned store:**
  - Stimulus: store 0x1234 to 0x22.
  - Response: `MisalignM` = 1 and stays high. `AckM` in cycle 1. A subsequent load of 0x20 returns 0, showing no write occurred.
- **`test_value`, with `TEST_ADDR` = 0:**
  - Stimulus: store 0xABCD5678 to 0x0.
  - Response: `test_value` = 0x5678 from the ACK cycle onward. A store to 0x400 (wraps to word 0 with ADDR_W = 8) overwrites it.
- **Reset mid-access:**
  - Stimulus: assert `RST` = 0 during WAIT of a store to 0x8.
  - Response: `StallMem`, `AckM` and `MisalignM` go to 0 immediately. After release, a load of 0x8 returns 0.
- **Input changes during WAIT:**
  - Stimulus: change `AddrM` and `WDataM` while in WAIT, and hold `ReqM` high through ACK.
  - Response: the write goes to the originally latched address with the latched data. Exactly one `AckM` pulse is produced, and IDLE is re-entered before a new acceptance.
